// File: rtl/div_share_if.sv
// Bundle of client-side and divider-side signals around div_share_arbiter.
// slave = the arbiter; master = the clients plus the shared divider.
interface div_share_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_q;
  logic [W-1:0]      rsp_r;
  logic              busy;
  logic              div_start;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic              div_ready;
  logic [W-1:0]      div_q;
  logic [W-1:0]      div_r;

  modport master (
    output req, a_in, b_in, div_ready, div_q, div_r,
    input  gnt, rsp_valid, rsp_q, rsp_r, busy, div_start, div_a, div_b
  );

  modport slave (
    input  req, a_in, b_in, div_ready, div_q, div_r,
    output gnt, rsp_valid, rsp_q, rsp_r, busy, div_start, div_a, div_b
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one sequential divider among NREQ clients.
// Optional macro DIV_ZERO_BYPASS_EN: answer b==0 locally (q=all ones, r=a) without the divider.
module div_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  div_share_if.slave   bus
);
  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            byp_q, byp_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_q_q, rsp_q_d;
  logic [W-1:0]    rsp_r_q, rsp_r_d;
  logic            busy_q, busy_d;
  logic            div_start_q, div_start_d;
  logic [W-1:0]    div_a_q, div_a_d;
  logic [W-1:0]    div_b_q, div_b_d;

  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic            found;
  logic [IW-1:0]   sel;
  logic [IW:0]     scan;
  logic [IW:0]     nxt;
  logic [IW-1:0]   rr_next;
  logic            zero_hit;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = bus.a_in[gi*W +: W];
    assign b_arr[gi] = bus.b_in[gi*W +: W];
  end

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (!found && bus.req[scan[IW-1:0]]) begin
        found = 1'b1;
        sel   = scan[IW-1:0];
      end
    end
    nxt     = {1'b0, sel} + (IW+1)'(1);
    rr_next = (nxt == (IW+1)'(NREQ)) ? '0 : nxt[IW-1:0];
  end

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_hit = (b_arr[sel] == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    byp_d       = 1'b0;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_q_d     = rsp_q_q;
    rsp_r_d     = rsp_r_q;
    div_start_d = div_start_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    case (state_q)
      S_IDLE: begin
        // A bypassed grant answers in the following cycle; no new grant meanwhile.
        if (byp_q) begin
          rsp_valid_d = ONE_HOT0 << idx_q;
          rsp_q_d     = '1;
          rsp_r_d     = div_a_q;
        end else if (found) begin
          gnt_d   = ONE_HOT0 << sel;
          idx_d   = sel;
          rr_d    = rr_next;
          div_a_d = a_arr[sel];
          div_b_d = b_arr[sel];
          if (zero_hit) begin
            byp_d = 1'b1;
          end else begin
            state_d     = S_LAUNCH;
            div_start_d = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (!bus.div_ready) begin
          div_start_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.div_ready) begin
          rsp_q_d     = bus.div_q;
          rsp_r_d     = bus.div_r;
          rsp_valid_d = ONE_HOT0 << idx_q;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        div_start_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      idx_q       <= '0;
      byp_q       <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_q_q     <= '0;
      rsp_r_q     <= '0;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      byp_q       <= byp_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q_q     <= rsp_q_d;
      rsp_r_q     <= rsp_r_d;
      busy_q      <= busy_d;
      div_start_q <= div_start_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.busy      = busy_q;
  assign bus.div_start = div_start_q;
  assign bus.div_a     = div_a_q;
  assign bus.div_b     = div_b_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural multi-cycle divider.
// Expected results are hand-computed constants.
module tb_div_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_share_if #(.NREQ(NREQ), .W(W)) ifc ();
  div_share_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int div_lat = 16;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider: ready low for div_lat cycles after an accepted start.
  logic         m_ready = 1'b1;
  logic [W-1:0] m_q = '0, m_r = '0, ma = '0, mb = '0;
  int           m_cnt = 0;
  assign ifc.div_ready = m_ready;
  assign ifc.div_q     = m_q;
  assign ifc.div_r     = m_r;

  always @(posedge clk) begin
    if (!m_ready) begin
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else begin
        m_ready <= 1'b1;
        m_q     <= (mb == 0) ? {W{1'b1}} : ma / mb;
        m_r     <= (mb == 0) ? ma : ma % mb;
      end
    end else if (ifc.div_start) begin
      m_ready <= 1'b0;
      m_cnt   <= div_lat;
      ma      <= ifc.div_a;
      mb      <= ifc.div_b;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_ctrl", {54'd0, ifc.gnt, ifc.rsp_valid, ifc.busy, ifc.div_start}, 64'd0);
    check("rst_data", {ifc.rsp_q, ifc.rsp_r, ifc.div_a, ifc.div_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g, output int t);
    g = '0;
    t = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifc.gnt != 0) begin
        g = ifc.gnt;
        t = cyc;
        return;
      end
    end
    check("gnt_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_rsp(output logic [NREQ-1:0] v, output int t, output int starts);
    v = '0;
    t = 0;
    starts = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.div_start) starts++;
      if (ifc.rsp_valid != 0) begin
        v = ifc.rsp_valid;
        t = cyc;
        return;
      end
    end
    check("rsp_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int lat, input int exp_starts);
    logic [NREQ-1:0] g, v;
    int t0, t1, st, st2;
    ifc.a_in[c*W +: W] = a;
    ifc.b_in[c*W +: W] = b;
    ifc.req[c] = 1'b1;
    wait_gnt(g, t0);
    st = ifc.div_start ? 1 : 0;
    check("gnt", 64'(g), 64'(4'b0001 << c));
    check("busy_at_gnt", 64'(ifc.busy), 64'(exp_starts != 0));
    check("div_a", 64'(ifc.div_a), 64'(a));
    check("div_b", 64'(ifc.div_b), 64'(b));
    ifc.req[c] = 1'b0;
    wait_rsp(v, t1, st2);
    check("rsp_valid", 64'(v), 64'(4'b0001 << c));
    check("rsp_q", 64'(ifc.rsp_q), 64'(eq));
    check("rsp_r", 64'(ifc.rsp_r), 64'(er));
    check("latency", 64'(t1 - t0), 64'(lat));
    check("start_cycles", 64'(st + st2), 64'(exp_starts));
    $display("op client=%0d a=%0d b=%0d q=%0d r=%0d latency=%0d", c, a, b, ifc.rsp_q, ifc.rsp_r, t1 - t0);
  endtask

  typedef struct {
    int         c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [NREQ-1:0] g, v;
    int t0, t1, st;
    logic [NREQ-1:0] exp_seq [5];
    logic [W-1:0] rq [4];
    logic [W-1:0] rr [4];
    int pulses;

    vecs[0] = '{0, 16'd90,    16'd13,  16'd6,     16'd12};
    vecs[1] = '{1, 16'd1000,  16'd7,   16'd142,   16'd6};
    vecs[2] = '{2, 16'd65535, 16'd256, 16'd255,   16'd255};
    vecs[3] = '{3, 16'd100,   16'd10,  16'd10,    16'd0};
    vecs[4] = '{1, 16'd5,     16'd9,   16'd0,     16'd5};
    vecs[5] = '{3, 16'd12345, 16'd1,   16'd12345, 16'd0};

    ifc.req  = '0;
    ifc.a_in = '0;
    ifc.b_in = '0;
    do_reset();

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, W + 2, 2);

    // All four clients request continuously: strict rotation from pointer 0.
    do_reset();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rq = '{16'd6, 16'd142, 16'd255, 16'd10};
    rr = '{16'd12, 16'd6, 16'd255, 16'd0};
    for (int c = 0; c < 4; c++) begin
      ifc.a_in[c*W +: W] = vecs[c].a;
      ifc.b_in[c*W +: W] = vecs[c].b;
    end
    ifc.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, t0);
      check("rr_gnt", 64'(g), 64'(exp_seq[i]));
      if (i == 4) ifc.req = '0;
      wait_rsp(v, t1, st);
      check("rr_rsp_valid", 64'(v), 64'(exp_seq[i]));
      for (int c = 0; c < 4; c++)
        if (exp_seq[i][c]) begin
          check("rr_q", 64'(ifc.rsp_q), 64'(rq[c]));
          check("rr_r", 64'(ifc.rsp_r), 64'(rr[c]));
        end
      $display("rr grant=%b q=%0d r=%0d", g, ifc.rsp_q, ifc.rsp_r);
    end

    // Client 2 re-requests in its response cycle while client 3 waits.
    do_reset();
    ifc.req = 4'b0100;
    wait_gnt(g, t0);
    check("c2_gnt", 64'(g), 64'(4'b0100));
    ifc.req = 4'b1000;
    wait_rsp(v, t1, st);
    check("c2_rsp", 64'(v), 64'(4'b0100));
    ifc.req[2] = 1'b1;
    wait_gnt(g, t0);
    check("c3_after_c2", 64'(g), 64'(4'b1000));
    ifc.req[3] = 1'b0;
    wait_rsp(v, t1, st);
    check("c3_q", 64'(ifc.rsp_q), 64'(16'd10));
    wait_gnt(g, t0);
    check("c2_again", 64'(g), 64'(4'b0100));
    ifc.req[2] = 1'b0;
    wait_rsp(v, t1, st);
    check("c2_again_r", 64'(ifc.rsp_r), 64'(16'd255));
    $display("no-starvation sequence q=%0d r=%0d", ifc.rsp_q, ifc.rsp_r);

    // Reset in the middle of a division: result must be discarded.
    ifc.a_in[0 +: W] = 16'd90;
    ifc.b_in[0 +: W] = 16'd13;
    ifc.req = 4'b0001;
    wait_gnt(g, t0);
    ifc.req = '0;
    repeat (8) @(negedge clk);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.rsp_valid != 0) pulses++;
    end
    check("no_rsp_after_rst", 64'(pulses), 64'd0);
    $display("reset mid-divide, stray responses=%0d", pulses);
    run_op(1, 16'd1000, 16'd7, 16'd142, 16'd6, W + 2, 2);

    // Slow divider: response follows div_ready, start drops on acceptance.
    div_lat = 40;
    run_op(1, 16'd1000, 16'd7, 16'd142, 16'd6, 42, 2);
    run_op(3, 16'd50000, 16'd3, 16'd16666, 16'd2, 42, 2);
    div_lat = W;

`ifdef DIV_ZERO_BYPASS_EN
    run_op(0, 16'd55, 16'd0, 16'hFFFF, 16'd55, 1, 0);
`else
    run_op(0, 16'd55, 16'd0, 16'hFFFF, 16'd55, W + 2, 2);
`endif
    run_op(2, 16'd77, 16'd7, 16'd11, 16'd0, W + 2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
